// File: rtl/apb_master_rmw_if.sv
// apb_master_rmw_if: command, response and APB bus signals of the RMW APB master
interface apb_master_rmw_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              psel;
  logic              penable;
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;
  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, pready, prdata, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           psel, penable, paddr, pwrite, pwdata
  );
  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, pready, prdata, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           psel, penable, paddr, pwrite, pwdata
  );
endinterface

// File: rtl/apb_master_rmw.sv
// apb_master_rmw: command-driven APB master with read, write, RMW add and wait-state timeout
module apb_master_rmw #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input logic clk,
  input logic rst,
  apb_master_rmw_if.master bus
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  state_t state, state_nx;
  logic rmw, rmw_rd, expire;
  logic [DATA_W-1:0] rd_lat;
  logic [TO_W-1:0] cnt;
  // an RMW is in its read phase until the write direction is switched on
  assign rmw_rd = rmw && !bus.pwrite;
  // the wait that would push the counter to TIMEOUT aborts instead
  assign expire = TIMEOUT != 0 && !bus.pready && cnt == TO_LAST;
  assign bus.cmd_ready = state == IDLE;
  assign bus.psel = state != IDLE;
  assign bus.penable = state == ACCESS;
  // next state: successful RMW read phase loops straight back to SETUP
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.cmd_valid ? SETUP : IDLE;
      SETUP:   state_nx = ACCESS;
      ACCESS:  state_nx = bus.pready ? (rmw_rd && !bus.pslverr ? SETUP : IDLE) : expire ? IDLE : ACCESS;
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // bus-side registers, wait counter and one-cycle response; during an RMW read
  // phase pwdata holds the addend so the write data is prdata + pwdata
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.paddr <= '0;
      bus.pwrite <= 1'b0;
      bus.pwdata <= '0;
      rmw <= 1'b0;
      rd_lat <= '0;
      cnt <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err <= 1'b0;
      bus.rsp_timeout <= 1'b0;
      if (state == IDLE && bus.cmd_valid) begin
        bus.paddr <= bus.cmd_addr;
        bus.pwrite <= bus.cmd_op == 2'b01;
        bus.pwdata <= bus.cmd_wdata;
        rmw <= bus.cmd_op == 2'b10;
      end
      if (state == SETUP) cnt <= '0;
      if (state == ACCESS) begin
        if (bus.pready && rmw_rd && !bus.pslverr) begin
          bus.pwrite <= 1'b1;
          bus.pwdata <= bus.prdata + bus.pwdata;
          rd_lat <= bus.prdata;
        end else if (bus.pready || expire) begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_err <= bus.pslverr || !bus.pready;
          bus.rsp_timeout <= !bus.pready;
          bus.rsp_rdata <= !bus.pready ? '0 : bus.pwrite ? (rmw ? rd_lat : '0) : bus.prdata;
        end else cnt <= cnt + 1'b1;
      end
    end
  end
endmodule
